// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ADD/SUB, WIDTH-cycle shift-add MUL and restoring DIV.
// Define ALU_SEQ_REM_EN to return the division remainder in the upper half of Y.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           control,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   Y,
  output logic                 dz
);

  localparam int unsigned YW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t          state, state_next;
  logic [YW-1:0]   acc, acc_next;
  logic [YW-1:0]   sh, sh_next;
  logic [WIDTH-1:0] opb, opb_next;
  logic [3:0]      ctl, ctl_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [YW-1:0]   y_next;
  logic            busy_next, done_next, dz_next;

  logic            ctl_ok;
  logic [WIDTH:0]  add_sum;
  logic [WIDTH-1:0] sub_diff;
  logic [YW-1:0]   mul_step;
  logic [WIDTH:0]  rem_shift, rem_diff;
  logic [YW-1:0]   div_step, div_result, divz_result;

  // acc holds {remainder, quotient} during DIV and the running product during MUL
  always_comb begin
    ctl_ok    = (control != 4'd0) && ((control & (control - 4'd1)) == 4'd0);
    add_sum   = {1'b0, A} + {1'b0, B};
    sub_diff  = A - B;
    mul_step  = opb[0] ? (acc + sh) : acc;
    rem_shift = {acc[YW-1:WIDTH], acc[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, opb};
    if (rem_diff[WIDTH]) begin
      div_step = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      div_step = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
`ifdef ALU_SEQ_REM_EN
    div_result  = div_step;
    divz_result = {A, {WIDTH{1'b1}}};
`else
    div_result  = {WIDTH'(0), div_step[WIDTH-1:0]};
    divz_result = {WIDTH'(0), {WIDTH{1'b1}}};
`endif
  end

  // Next-state and next-register logic
  always_comb begin
    state_next = state;
    acc_next   = acc;
    sh_next    = sh;
    opb_next   = opb;
    ctl_next   = ctl;
    cnt_next   = cnt;
    y_next     = Y;
    dz_next    = dz;
    busy_next  = busy;
    done_next  = 1'b0;

    unique case (state)
      IDLE: begin
        if (start && ctl_ok) begin
          ctl_next  = control;
          opb_next  = B;
          cnt_next  = '0;
          busy_next = 1'b1;
          if (control[0]) begin
            y_next     = YW'(add_sum);
            dz_next    = 1'b0;
            done_next  = 1'b1;
            state_next = FIN;
          end else if (control[1]) begin
            y_next     = YW'({(A < B), sub_diff});
            dz_next    = 1'b0;
            done_next  = 1'b1;
            state_next = FIN;
          end else if (control[2]) begin
            acc_next   = '0;
            sh_next    = YW'(A);
            state_next = CALC;
          end else if (B == '0) begin
            y_next     = divz_result;
            dz_next    = 1'b1;
            done_next  = 1'b1;
            state_next = FIN;
          end else begin
            acc_next   = YW'(A);
            state_next = CALC;
          end
        end
      end
      CALC: begin
        cnt_next = cnt + CW'(1);
        if (ctl[2]) begin
          acc_next = mul_step;
          sh_next  = sh << 1;
          opb_next = opb >> 1;
        end else begin
          acc_next = div_step;
        end
        if (cnt == CW'(WIDTH - 1)) begin
          cnt_next   = '0;
          y_next     = ctl[2] ? mul_step : div_result;
          dz_next    = 1'b0;
          done_next  = 1'b1;
          state_next = FIN;
        end
      end
      FIN: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      sh    <= '0;
      opb   <= '0;
      ctl   <= '0;
      cnt   <= '0;
      Y     <= '0;
      dz    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      sh    <= sh_next;
      opb   <= opb_next;
      ctl   <= ctl_next;
      cnt   <= cnt_next;
      Y     <= y_next;
      dz    <= dz_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed and random ops checked against an arithmetic model.
module tb_alu_seq;

  localparam int W = 8;

  typedef struct {
    logic [2*W-1:0] y;
    logic           dz;
    int             lat;
    int             acc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [3:0]     control = 4'd0;
  logic [W-1:0]   A = '0, B = '0;
  logic           busy, done, dz;
  logic [2*W-1:0] Y;

  logic           start16 = 1'b0;
  logic [3:0]     control16 = 4'd0;
  logic [15:0]    a16 = '0, b16 = '0;
  logic           busy16, done16, dz16;
  logic [31:0]    y16;

  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  exp_t q[$];
  exp_t mon_e;
  logic [2*W-1:0] last_y = '0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .control(control), .A(A), .B(B),
    .busy(busy), .done(done), .Y(Y), .dz(dz)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .control(control16), .A(a16), .B(b16),
    .busy(busy16), .done(done16), .Y(y16), .dz(dz16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  // Reference model: plain arithmetic on the operands
  function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int unsigned ai, bi;
    ai = a; bi = b;
    e.dz = 1'b0; e.lat = 1; e.acc = 0;
    case (c)
      4'b0001: e.y = (2*W)'(ai + bi);
      4'b0010: e.y = (2*W)'(((ai < bi) ? 256 : 0) + ((ai - bi) & 32'hFF));
      4'b0100: begin e.y = (2*W)'(ai * bi); e.lat = W + 1; end
      default: begin
        if (bi == 0) begin
          e.dz = 1'b1;
`ifdef ALU_SEQ_REM_EN
          e.y = (2*W)'(ai * 256 + 255);
`else
          e.y = (2*W)'(255);
`endif
        end else begin
          e.lat = W + 1;
`ifdef ALU_SEQ_REM_EN
          e.y = (2*W)'((ai % bi) * 256 + ai / bi);
`else
          e.y = (2*W)'(ai / bi);
`endif
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: pop and compare whenever done is seen
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        chk(1'b0, "spurious_done", 64'(Y), 64'd0);
      end else begin
        mon_e = q.pop_front();
        chk(Y == mon_e.y, "Y", 64'(Y), 64'(mon_e.y));
        chk(dz == mon_e.dz, "dz", 64'(dz), 64'(mon_e.dz));
        chk(cyc - mon_e.acc + 1 == mon_e.lat, "latency", 64'(cyc - mon_e.acc + 1), 64'(mon_e.lat));
      end
    end
  end

  // Issue one request at a negedge while idle, toggle noise while busy, return busy length
  task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b, output int bcnt);
    exp_t e;
    start = 1'b1; control = c; A = a; B = b;
    if ($onehot(c)) begin
      e = model(c, a, b);
      e.acc = cyc + 1;
      q.push_back(e);
      last_y = e.y;
    end
    @(negedge clk);
    bcnt = 0;
    while (busy && bcnt < 100) begin
      bcnt++;
      start = 1'($urandom); control = 4'($urandom); A = W'($urandom); B = W'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    if (bcnt >= 100) chk(1'b0, "busy_timeout", 64'(bcnt), 64'd0);
    if (!$onehot(c)) begin
      chk(bcnt == 0, "ignored_busy", 64'(bcnt), 64'd0);
      chk(Y == last_y, "ignored_Y", 64'(Y), 64'(last_y));
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int bc;
    int n;
    logic [3:0] c;
    logic [W-1:0] a, b;

    repeat (2) @(negedge clk);
    chk(busy == 1'b0, "rst_busy", 64'(busy), 64'd0);
    chk(done == 1'b0, "rst_done", 64'(done), 64'd0);
    chk(Y == '0, "rst_Y", 64'(Y), 64'd0);
    chk(dz == 1'b0, "rst_dz", 64'(dz), 64'd0);
    rst = 1'b0;

    run_op(4'b0001, 8'hFF, 8'h01, bc);
    chk(bc == 1, "add_busy_len", 64'(bc), 64'd1);
    run_op(4'b0010, 8'h03, 8'h05, bc);
    run_op(4'b0010, 8'h05, 8'h03, bc);
    run_op(4'b0100, 8'hFF, 8'hFF, bc);
    chk(bc == 9, "mul_busy_len", 64'(bc), 64'd9);
    run_op(4'b1000, 8'd200, 8'd7, bc);
    run_op(4'b1000, 8'h55, 8'h00, bc);
    chk(bc == 1, "divz_busy_len", 64'(bc), 64'd1);
    run_op(4'b0011, 8'h12, 8'h34, bc);
    run_op(4'b0000, 8'h12, 8'h34, bc);

    // Abort a MUL three cycles in with an asynchronous reset
    start = 1'b1; control = 4'b0100; A = 8'hAB; B = 8'hCD;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk(busy == 1'b0, "arst_busy", 64'(busy), 64'd0);
    chk(done == 1'b0, "arst_done", 64'(done), 64'd0);
    chk(Y == '0, "arst_Y", 64'(Y), 64'd0);
    chk(dz == 1'b0, "arst_dz", 64'(dz), 64'd0);
    last_y = '0;
    @(negedge clk);
    rst = 1'b0;
    run_op(4'b0001, 8'd2, 8'd2, bc);
    repeat (12) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) c = 4'($urandom);
      else c = 4'b0001 << $urandom_range(0, 3);
      a = W'($urandom);
      b = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
      if ($urandom_range(0, 6) == 0) b = a;
      run_op(c, a, b, bc);
    end

    n = 0;
    while (q.size() != 0 && n < 20) begin n++; @(negedge clk); end
    chk(q.size() == 0, "drain", 64'(q.size()), 64'd0);

    // Wide multiply on the 16-bit instance
    start16 = 1'b1; control16 = 4'b0100; a16 = 16'hFFFF; b16 = 16'hFFFF;
    @(negedge clk);
    start16 = 1'b0; a16 = 16'h1234; b16 = 16'h0002;
    n = 1;
    while (!done16 && n < 40) begin
      start16 = 1'($urandom);
      n++;
      @(negedge clk);
    end
    start16 = 1'b0;
    chk(n == 17, "mul16_latency", 64'(n), 64'd17);
    chk(y16 == 32'hFFFE0001, "mul16_Y", 64'(y16), 64'hFFFE0001);
    chk(dz16 == 1'b0, "mul16_dz", 64'(dz16), 64'd0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal range 4..32.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled only while busy=0.
REQ-005 control  input  4  one-hot op: 0001 ADD, 0010 SUB, 0100 MUL, 1000 DIV.
REQ-006 A  input  WIDTH  first operand, unsigned.
REQ-007 B  input  WIDTH  second operand, unsigned.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  single-cycle pulse: Y and dz valid and updated.
REQ-010 Y  output  2*WIDTH  result register.
REQ-011 dz  output  1  divide-by-zero flag for the most recent completed op.

Function
REQ-012 FSM states IDLE, CALC, FIN; busy=1 in CALC and FIN, 0 in IDLE.
REQ-013 IDLE: start=1 with valid one-hot control -> capture A, B, control; ADD/SUB/DIV-by-zero -> FIN; MUL/DIV with B!=0 -> CALC, iteration counter=0.
REQ-014 IDLE: start=1 with control not one-hot (incl. 0000) -> request ignored; no state change, no done, Y and dz unchanged.
REQ-015 start while busy=1 ignored; operands captured at acceptance, later A/B/control changes have no effect.
REQ-016 ADD: Y = zero-extended (WIDTH+1)-bit A+B (carry in Y[WIDTH]); dz=0.
REQ-017 SUB: Y[WIDTH-1:0] = (A-B) mod 2^WIDTH; Y[WIDTH] = 1 iff A<B; upper bits 0; dz=0.
REQ-018 MUL: radix-2 shift-add, one multiplier bit per cycle; Y = A*B (full 2*WIDTH bits); dz=0.
REQ-019 DIV: restoring division, one quotient bit per cycle; Y[WIDTH-1:0] = A/B (floor); dz=0.
REQ-020 DIV with B=0: no iteration; Y[WIDTH-1:0] = all ones; dz=1.
REQ-021 CALC runs exactly WIDTH cycles then -> FIN; FIN lasts one cycle, writes Y/dz, pulses done, -> IDLE.
REQ-022 Latency, accepting edge to done high: ADD, SUB, DIV-by-zero = 1 cycle; MUL, DIV = WIDTH+1 cycles.
REQ-023 start may be reasserted in the cycle done=1 is high is NOT accepted (busy=1); first acceptable cycle is the one after done.
REQ-024 Y and dz hold their value between done pulses; intermediate values never visible on Y.

Reset
REQ-025 rst=1 forces immediately, independent of clk: state IDLE, busy=0, done=0, Y=0, dz=0, counter=0, internal operand registers 0.
REQ-026 rst mid-operation aborts it; no done is produced for the aborted op.
REQ-027 First start accepted on the first rising edge after rst deasserts.

Configuration
REQ-028 Macro ALU_SEQ_REM_EN defined: DIV places remainder A mod B in Y[2*WIDTH-1:WIDTH]; DIV-by-zero places A there.
REQ-029 ALU_SEQ_REM_EN undefined: Y[2*WIDTH-1:WIDTH] = 0 for every DIV result; remainder datapath not driven to output.

Verification
REQ-030 WIDTH=8: ADD A=0xFF B=0x01 -> done 1 cycle after accept, Y=0x0100, dz=0.
REQ-031 WIDTH=8: SUB A=0x03 B=0x05 -> Y=0x01FE, dz=0; SUB A=5 B=3 -> Y=0x0002.
REQ-032 WIDTH=8: MUL A=0xFF B=0xFF -> busy 9 cycles, done 9 cycles after accept, Y=0xFE01; start pulses during busy ignored.
REQ-033 WIDTH=8: DIV A=200 B=7 -> done after 9 cycles, Y=0x041C with ALU_SEQ_REM_EN, 0x001C without; DIV A=0x55 B=0 -> done after 1 cycle, dz=1, Y=0x55FF / 0x00FF.
REQ-034 rst asserted 3 cycles into MUL -> busy, done, Y, dz =0 at once; no done afterwards; next ADD 2+2 -> Y=0x0004.
REQ-035 control=0011 with start=1 in IDLE -> busy stays 0, no done, Y unchanged; repeat REQ-032 at WIDTH=16 with A=B=0xFFFF -> Y=0xFFFE0001 after 17 cycles.
